// File: rtl/keycode_move_ctrl.sv
// keycode_move_ctrl: turns the registered PIO keycode into player step requests with
// press-then-auto-repeat timing, and A/B keys into single-cycle press pulses.
// Latency: keycode -> kc_q (1 edge) -> step_valid (1 more edge); btn_a/btn_b decode kc_q directly.
// Backpressure: single step slot held until step_ready; an issue that finds the slot busy is dropped.
//
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   keycode[7:0]         current key from the PIO, 8'h00 = no key
//   step_valid/step_dir  step request to the motion engine, dir stable while valid
//   step_ready           motion engine accepts when step_valid && step_ready
//   btn_a, btn_b         one-cycle pulses on confirm/cancel press
//   held                 high while a direction key is being held
module keycode_move_ctrl #(
  parameter int unsigned DELAY_CYC  = 12_500_000,
  parameter int unsigned PERIOD_CYC = 5_000_000,
  parameter logic [7:0]  KEY_UP     = 8'h1A,
  parameter logic [7:0]  KEY_LEFT   = 8'h04,
  parameter logic [7:0]  KEY_DOWN   = 8'h16,
  parameter logic [7:0]  KEY_RIGHT  = 8'h07,
  parameter logic [7:0]  KEY_A      = 8'h28,
  parameter logic [7:0]  KEY_B      = 8'h29
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  output logic       step_valid,
  output logic [1:0] step_dir,
  input  logic       step_ready,
  output logic       btn_a,
  output logic       btn_b,
  output logic       held
);

  localparam int unsigned MAX_CYC = (DELAY_CYC > PERIOD_CYC) ? DELAY_CYC : PERIOD_CYC;
  localparam int          CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(PERIOD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       kc_q, kc_prev_q;
  logic [1:0]       key_dir_q, key_dir_d;   // direction of the key currently held
  logic             held_q;

  logic             dir_hit;
  logic [1:0]       dir_code;
  logic             issue;
  logic             accept;
  logic             load;

  // Keycode registers: all decode works from kc_q so the PIO write is never seen mid-cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kc_q      <= '0;
      kc_prev_q <= '0;
    end else begin
      kc_q      <= keycode;
      kc_prev_q <= kc_q;
    end
  end

  // Direction decode; every other code (including A/B) counts as "no direction".
  always_comb begin
    dir_hit  = 1'b1;
    dir_code = 2'b00;
    if (kc_q == KEY_UP) begin
      dir_code = 2'b00;
    end else if (kc_q == KEY_LEFT) begin
      dir_code = 2'b01;
    end else if (kc_q == KEY_DOWN) begin
      dir_code = 2'b10;
    end else if (kc_q == KEY_RIGHT) begin
      dir_code = 2'b11;
    end else begin
      dir_hit = 1'b0;
    end
  end

  // FSM state, repeat counter and held-direction registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_dir_q <= 2'b00;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_dir_q <= key_dir_d;
      held_q    <= (state_d != IDLE);
    end
  end

  // Next state. The counter only runs while no step is pending, so a stalled
  // motion engine stretches the repeat interval instead of dropping steps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_dir_d = key_dir_q;
    issue     = 1'b0;

    case (state_q)
      IDLE: begin
        if (dir_hit) begin
          issue     = 1'b1;
          key_dir_d = dir_code;
          cnt_d     = DELAY_LOAD;
          state_d   = DELAY;
        end
      end

      DELAY, REPEAT: begin
        if (!dir_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (dir_code != key_dir_q) begin
          // Rolling onto another direction acts as a fresh press.
          issue     = 1'b1;
          key_dir_d = dir_code;
          cnt_d     = DELAY_LOAD;
          state_d   = DELAY;
        end else if (cnt_q == '0) begin
          issue   = 1'b1;
          cnt_d   = PERIOD_LOAD;
          state_d = REPEAT;
        end else if (!step_valid) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Single-entry step slot. A new issue may reuse the slot in the same cycle the
  // previous step is accepted; otherwise a busy slot swallows the issue.
  assign accept = step_valid && step_ready;
  assign load   = issue && (!step_valid || step_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_valid <= 1'b0;
      step_dir   <= 2'b00;
    end else if (load) begin
      step_valid <= 1'b1;
      step_dir   <= dir_code;
    end else if (accept) begin
      step_valid <= 1'b0;
    end
  end

  // Press pulses from the two registered keycode stages: glitch-free and cleared by reset.
  assign btn_a = (kc_q == KEY_A) && (kc_prev_q != KEY_A);
  assign btn_b = (kc_q == KEY_B) && (kc_prev_q != KEY_B);
  assign held  = held_q;

endmodule

// File: tb/tb_keycode_move_ctrl.sv
// tb_keycode_move_ctrl: directed scenarios followed by randomized key/ready traffic,
// every cycle compared against a behavioural model of the press/repeat rules.
// Inputs change just after the falling edge; outputs are compared at the falling edge.
module tb_keycode_move_ctrl;

  localparam int DLY = 8;
  localparam int PER = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       step_ready = 1'b0;
  logic       step_valid;
  logic [1:0] step_dir;
  logic       btn_a;
  logic       btn_b;
  logic       held;

  always #5 clk = ~clk;

  keycode_move_ctrl #(
    .DELAY_CYC (DLY),
    .PERIOD_CYC(PER)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .keycode   (keycode),
    .step_valid(step_valid),
    .step_dir  (step_dir),
    .step_ready(step_ready),
    .btn_a     (btn_a),
    .btn_b     (btn_b),
    .held      (held)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state: what the block should look like after each edge.
  logic [7:0] m_kc;
  logic [7:0] m_kc_prev;
  int         m_key;      // held direction 0..3, -1 when nothing held
  int         m_quiet;    // cycles without a pending step since the last issue
  int         m_target;   // quiet cycles needed before the next issue
  bit         m_valid;
  logic [1:0] m_dir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int dir_of(input logic [7:0] k);
    case (k)
      8'h1A:   return 0;
      8'h04:   return 1;
      8'h16:   return 2;
      8'h07:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_kc      = 8'h00;
    m_kc_prev = 8'h00;
    m_key     = -1;
    m_quiet   = 0;
    m_target  = DLY;
    m_valid   = 1'b0;
    m_dir     = 2'b00;
  endtask

  // One clock edge of behaviour, from the rules: press -> step, hold -> wait
  // DLY then PER idle-slot cycles between steps, busy slot drops the issue.
  task automatic model_step();
    int d;
    int nd;
    bit iss;
    bit acc;
    d   = dir_of(m_kc);
    nd  = d;
    iss = 1'b0;
    if (m_key < 0) begin
      if (d >= 0) begin
        iss = 1'b1; m_key = d; m_quiet = 0; m_target = DLY;
      end
    end else if (d < 0) begin
      m_key = -1;
    end else if (d != m_key) begin
      iss = 1'b1; m_key = d; m_quiet = 0; m_target = DLY;
    end else begin
      if (!m_valid) m_quiet++;
      if (m_quiet >= m_target) begin
        iss = 1'b1; m_quiet = 0; m_target = PER;
      end
    end
    acc = m_valid && step_ready;
    if (iss && (!m_valid || acc)) begin
      m_valid = 1'b1;
      m_dir   = nd[1:0];
    end else if (acc) begin
      m_valid = 1'b0;
    end
    m_kc_prev = m_kc;
    m_kc      = keycode;
  endtask

  task automatic compare_all();
    chk("step_valid", {31'd0, step_valid}, {31'd0, m_valid});
    chk("step_dir",   {30'd0, step_dir},   {30'd0, m_dir});
    chk("btn_a", {31'd0, btn_a}, {31'd0, (m_kc == 8'h28) && (m_kc_prev != 8'h28)});
    chk("btn_b", {31'd0, btn_b}, {31'd0, (m_kc == 8'h29) && (m_kc_prev != 8'h29)});
    chk("held",  {31'd0, held},  {31'd0, m_key >= 0});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q[$];
    int n;
    int na;
    int nb;
    int ns;
    int segs;
    int len;
    int bias;
    int r;

    model_reset();

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_step_valid", {31'd0, step_valid}, 32'd0);
    chk("rst_step_dir",   {30'd0, step_dir},   32'd0);
    chk("rst_btn",        {30'd0, btn_a, btn_b}, 32'd0);
    chk("rst_held",       {31'd0, held},       32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick();

    // 1: single-cycle tap of up
    step_ready = 1'b1;
    keycode = 8'h1A;
    tick();
    keycode = 8'h00;
    chk("t1_not_yet", {31'd0, step_valid}, 32'd0);
    tick();
    chk("t1_latency", {31'd0, step_valid}, 32'd1);
    chk("t1_dir",     {30'd0, step_dir},   32'd0);
    ns = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step_valid) ns++;
    end
    chk("t1_no_repeat", ns, 0);

    // 2: hold right, ready always high
    keycode = 8'h07;
    q.delete();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (step_valid) q.push_back(cyc);
    end
    chk("t2_nsteps", {31'd0, q.size() >= 4}, 32'd1);
    if (q.size() >= 2) chk("t2_first_gap", q[1] - q[0], 9);
    for (int i = 2; i < q.size(); i++) chk("t2_repeat_gap", q[i] - q[i-1], 5);
    keycode = 8'h00;
    repeat (4) tick();

    // 3: hold down with the motion engine stalled
    step_ready = 1'b0;
    keycode = 8'h16;
    repeat (2) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_valid_held", {31'd0, step_valid}, 32'd1);
      chk("t3_dir_stable", {30'd0, step_dir},   32'd2);
    end
    step_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!step_valid && n < 30);
    chk("t3_gap_after_accept", n, 9);
    keycode = 8'h00;
    repeat (4) tick();

    // 4: left, then roll onto up during the hold delay
    keycode = 8'h04;
    repeat (5) tick();
    keycode = 8'h1A;
    repeat (2) tick();
    chk("t4_switch_valid", {31'd0, step_valid}, 32'd1);
    chk("t4_switch_dir",   {30'd0, step_dir},   32'd0);
    repeat (6) tick();
    keycode = 8'h00;
    repeat (4) tick();

    // 5: A held, then B held
    na = 0; nb = 0; ns = 0;
    keycode = 8'h28;
    for (int i = 0; i < 10; i++) begin
      tick();
      na += btn_a; nb += btn_b; ns += step_valid;
    end
    keycode = 8'h29;
    for (int i = 0; i < 10; i++) begin
      tick();
      na += btn_a; nb += btn_b; ns += step_valid;
    end
    keycode = 8'h00;
    repeat (3) tick();
    chk("t5_btn_a_pulses", na, 1);
    chk("t5_btn_b_pulses", nb, 1);
    chk("t5_no_steps",     ns, 0);

    // 6: asynchronous reset while a step is stuck in the slot
    step_ready = 1'b0;
    keycode = 8'h16;
    repeat (3) tick();
    chk("t6_pending", {31'd0, step_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, step_valid}, 32'd0);
    chk("t6_async_dir",   {30'd0, step_dir},   32'd0);
    chk("t6_async_held",  {31'd0, held},       32'd0);
    keycode = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("t6_idle_after", {31'd0, held}, 32'd0);

    // Randomized traffic
    segs = 150;
    for (int s = 0; s < segs; s++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: keycode = 8'h1A;
        1: keycode = 8'h04;
        2: keycode = 8'h16;
        3: keycode = 8'h07;
        4: keycode = 8'h28;
        5: keycode = 8'h29;
        6: keycode = 8'h00;
        7: keycode = 8'($urandom_range(0, 255));
        default: keycode = keycode;
      endcase
      len  = $urandom_range(1, 20);
      bias = $urandom_range(0, 4);
      for (int i = 0; i < len; i++) begin
        step_ready = ($urandom_range(0, 3) < bias);
        tick();
      end
    end
    keycode = 8'h00;
    step_ready = 1'b1;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
